// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel accelerator datapath.
package sobel_pkg;

  localparam int PIXEL_W   = 24;
  localparam int IMG_WIDTH = 100;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Address width for a buffer of the given depth (never below 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/row_fifo_manager_line_buffer.sv
// One row of pixel storage: circular buffer, read-before-write at an external pointer.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH      = IMG_WIDTH,
  parameter int DATA_WIDTH = PIXEL_W,
  localparam int AW        = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [AW-1:0]         ptr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Contents are never reset; the manager masks them until they hold real pixels.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/row_fifo_manager.sv
// Three-row line-buffer manager feeding the 3x3 window stage.
// Optional status outputs (rows_valid, col_idx) are enabled by defining ROW_FIFO_STATUS_EN.
module row_fifo_manager
  import sobel_pkg::*;
#(
  parameter int WIDTH      = IMG_WIDTH,
  parameter int DATA_WIDTH = PIXEL_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          shift_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         row0,
  output logic [DATA_WIDTH-1:0]         row1,
  output logic [DATA_WIDTH-1:0]         row2
`ifdef ROW_FIFO_STATUS_EN
  ,
  output logic                          rows_valid,
  output logic [ptr_w(WIDTH)-1:0]       col_idx
`endif
);

  localparam int AW = ptr_w(WIDTH);
  localparam int CW = $clog2(2 * WIDTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_ROW  = CW'(WIDTH);
  localparam logic [CW-1:0] TWO_ROWS = CW'(2 * WIDTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
  logic [DATA_WIDTH-1:0] row0_q, row0_d;
  logic [DATA_WIDTH-1:0] row1_q, row1_d;
  logic [DATA_WIDTH-1:0] row2_q, row2_d;
  logic [DATA_WIDTH-1:0] a_rd, b_rd;

  // A holds the previous row; B receives what falls out of A, i.e. two rows back.
  line_buffer #(.DEPTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf_a (
    .clk     (clk),
    .en      (shift_en),
    .ptr     (wr_ptr_q),
    .wr_data (data_in),
    .rd_data (a_rd)
  );

  line_buffer #(.DEPTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf_b (
    .clk     (clk),
    .en      (shift_en),
    .ptr     (wr_ptr_q),
    .wr_data (a_rd),
    .rd_data (b_rd)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    row0_d     = row0_q;
    row1_d     = row1_q;
    row2_d     = row2_q;
    if (shift_en) begin
      wr_ptr_d   = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      fill_cnt_d = (fill_cnt_q == TWO_ROWS) ? fill_cnt_q : fill_cnt_q + CW'(1);
      row2_d     = data_in;
      // fill_cnt_q is the number of shifts before this one, so n = fill_cnt_q + 1.
      row1_d     = (fill_cnt_q >= ONE_ROW)  ? a_rd : '0;
      row0_d     = (fill_cnt_q >= TWO_ROWS) ? b_rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      row0_q     <= '0;
      row1_q     <= '0;
      row2_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      row0_q     <= row0_d;
      row1_q     <= row1_d;
      row2_q     <= row2_d;
    end
  end

  assign row0 = row0_q;
  assign row1 = row1_q;
  assign row2 = row2_q;

`ifdef ROW_FIFO_STATUS_EN
  logic          rows_valid_q, rows_valid_d;
  logic [AW-1:0] col_idx_q, col_idx_d;

  always_comb begin
    rows_valid_d = rows_valid_q;
    col_idx_d    = col_idx_q;
    if (shift_en) begin
      rows_valid_d = rows_valid_q | (fill_cnt_q >= TWO_ROWS);
      col_idx_d    = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_valid_q <= 1'b0;
      col_idx_q    <= '0;
    end else begin
      rows_valid_q <= rows_valid_d;
      col_idx_q    <= col_idx_d;
    end
  end

  assign rows_valid = rows_valid_q;
  assign col_idx    = col_idx_q;
`endif

endmodule

// File: tb/tb_row_fifo_manager.sv
// Directed bench for row_fifo_manager at WIDTH=100, DATA_WIDTH=24.
module tb_row_fifo_manager;

  localparam int W  = 100;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          shift_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] row0, row1, row2;
`ifdef ROW_FIFO_STATUS_EN
  logic          rows_valid;
  logic [6:0]    col_idx;
`endif

  int n_vec = 0;
  int n_err = 0;
  int e0 = 0, e1 = 0, e2 = 0, ev = 0, ec = 0;

  always #5 clk = ~clk;

  row_fifo_manager #(.WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en),
    .data_in    (data_in),
    .row0       (row0),
    .row1       (row1),
    .row2       (row2)
`ifdef ROW_FIFO_STATUS_EN
    ,
    .rows_valid (rows_valid),
    .col_idx    (col_idx)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".row0"}, int'(row0), e0);
    check({tag, ".row1"}, int'(row1), e1);
    check({tag, ".row2"}, int'(row2), e2);
`ifdef ROW_FIFO_STATUS_EN
    check({tag, ".rows_valid"}, int'(rows_valid), ev);
    check({tag, ".col_idx"}, int'(col_idx), ec);
`endif
  endtask

  // Accept pixel v as the n-th shift since reset; values are consecutive so
  // the pixel k shifts earlier is simply v-k.
  task automatic push(input int n, input int v);
    data_in  = DW'(v);
    shift_en = 1'b1;
    @(posedge clk);
    #1;
    e2 = v;
    e1 = (n > W)     ? v - W     : 0;
    e0 = (n > 2 * W) ? v - 2 * W : 0;
    ev = (n > 2 * W) ? 1 : 0;
    ec = (n - 1) % W;
    check_all($sformatf("shift n=%0d v=%0d", n, v));
  endtask

  task automatic idle(input int cycles, input string tag);
    shift_en = 1'b0;
    data_in  = '1;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("%s c=%0d", tag, k));
    end
  endtask

  initial begin
    // Power-on reset held for two cycles.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Stream 1..250, pause five cycles, resume 251..350.
    for (int i = 1; i <= 250; i++) push(i, i);
    idle(5, "pause");
    for (int i = 251; i <= 350; i++) push(i, i);

    // Asynchronous reset away from any edge: outputs must clear at once.
    #2;
    rst_n = 1'b0;
    #1;
    e0 = 0; e1 = 0; e2 = 0; ev = 0; ec = 0;
    check_all("async_reset");
    idle(2, "in_reset");
    rst_n = 1'b1;

    // Restream with distinct values; stale buffer contents must stay masked.
    for (int i = 1; i <= 210; i++) push(i, i + 5000);
    idle(2, "final_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
